// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the fetch stage.
//   WORD_W            : datapath / address width
//   INSTR_BYTES       : bytes per instruction word
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   NOP_INSTR_DEFAULT : sll $0,$0,0 encoding used for bubbles
//   pc_sel_e          : next-PC source chosen each cycle
//   align_word()      : clears the byte-offset bits of an address
package mips_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = '0;
   localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = '0;

   typedef enum logic [1:0] {
      PC_SEQ      = 2'd0,
      PC_HOLD     = 2'd1,
      PC_REDIRECT = 2'd2
   } pc_sel_e;

   function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : capture next_instr / next_pc / next_pc4, mark valid
//   squash            : replace instruction with NOP, clear valid, keep pc/pc4
//   next_instr/pc/pc4 : values captured on load
//   instr/pc/pc4      : registered outputs
//   valid             : register holds a real (non-squashed) instruction
// With neither load nor squash the register holds. Squash wins over load.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              squash,
   input  logic [WORD_W-1:0] next_instr,
   input  logic [WORD_W-1:0] next_pc,
   input  logic [WORD_W-1:0] next_pc4,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc4,
   output logic              valid
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr <= NOP_INSTR;
         pc    <= RESET_PC;
         pc4   <= RESET_PC + WORD_W'(INSTR_BYTES);
         valid <= 1'b0;
      end else if (squash) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         instr <= next_instr;
         pc    <= next_pc;
         pc4   <= next_pc4;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, fills IF/ID.
//   clk, reset       : clock, asynchronous active-high reset
//   stall            : hold PC and IF/ID (load-use hazard)
//   redirect_valid   : taken branch/jump; load redirect_target (beats stall)
//   redirect_target  : byte address of the next instruction
//   imem_addr        : ROM byte address (= pc, combinational)
//   imem_instr       : ROM data for imem_addr (zero latency)
//   if_id_instr/pc/pc4/valid : IF/ID pipeline register
//   fetch_misaligned : one-cycle pulse after a redirect whose target[1:0] != 0
//   fetch_count      : instructions accepted into IF/ID (wraps)
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_instr,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_pc4,
   output logic             if_id_valid,
   output logic             fetch_misaligned,
   output logic [CNT_W-1:0] fetch_count
);

   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_plus4;
   pc_sel_e           pc_sel;

   assign imem_addr = pc;
   assign pc_plus4  = pc + WORD_W'(INSTR_BYTES);

   always_comb begin
      pc_sel = PC_SEQ;
      if (redirect_valid) pc_sel = PC_REDIRECT;
      else if (stall)     pc_sel = PC_HOLD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc               <= RESET_PC;
         fetch_misaligned <= 1'b0;
         fetch_count      <= '0;
      end else begin
         unique case (pc_sel)
            PC_REDIRECT: begin
               // Low bits are dropped; the pulse only reports that they were set.
               pc               <= align_word(redirect_target);
               fetch_misaligned <= |redirect_target[1:0];
            end
            PC_HOLD: begin
               fetch_misaligned <= 1'b0;
            end
            default: begin
               pc               <= pc_plus4;
               fetch_misaligned <= 1'b0;
               fetch_count      <= fetch_count + CNT_W'(1);
            end
         endcase
      end
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (pc_sel == PC_SEQ),
      .squash     (pc_sel == PC_REDIRECT),
      .next_instr (imem_instr),
      .next_pc    (pc),
      .next_pc4   (pc_plus4),
      .instr      (if_id_instr),
      .pc         (if_id_pc),
      .pc4        (if_id_pc4),
      .valid      (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_misaligned;
   logic [31:0] fetch_count;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000),
      .CNT_W     (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .imem_addr        (imem_addr),
      .imem_instr       (imem_instr),
      .if_id_instr      (if_id_instr),
      .if_id_pc         (if_id_pc),
      .if_id_pc4        (if_id_pc4),
      .if_id_valid      (if_id_valid),
      .fetch_misaligned (fetch_misaligned),
      .fetch_count      (fetch_count)
   );

   // ROM: 256 words indexed by address[9:2], zero latency.
   logic [31:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      mem[2] = 32'h0109_5020;
      mem[3] = 32'hAC0A_0000;
   end
   assign imem_instr = mem[imem_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural effect of each edge, from the fetch rules.
   logic [31:0] m_pc, m_ii, m_ip, m_ip4, m_cnt;
   logic        m_v, m_mis;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 32'h0; m_ii = 32'h0; m_ip = 32'h0; m_ip4 = 32'h4;
         m_v = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
      end else if (redirect_valid) begin
         m_mis = (redirect_target % 4) != 0;
         m_pc  = redirect_target - (redirect_target % 4);
         m_ii  = 32'h0;
         m_v   = 1'b0;
      end else if (stall) begin
         m_mis = 1'b0;
      end else begin
         m_ii  = mem[(m_pc / 4) % 256];
         m_ip  = m_pc;
         m_ip4 = m_pc + 4;
         m_v   = 1'b1;
         m_pc  = m_pc + 4;
         m_cnt = m_cnt + 1;
         m_mis = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("imem_addr",   imem_addr,          m_pc);
         chk("if_id_instr", if_id_instr,        m_ii);
         chk("if_id_pc",    if_id_pc,           m_ip);
         chk("if_id_pc4",   if_id_pc4,          m_ip4);
         chk("if_id_valid", 32'(if_id_valid),   32'(m_v));
         chk("misaligned",  32'(fetch_misaligned), 32'(m_mis));
         chk("fetch_count", fetch_count,        m_cnt);
      end
   end

   task automatic step(input logic s, input logic r, input logic [31:0] t);
      stall = s; redirect_valid = r; redirect_target = t;
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_addr"},  imem_addr,             32'h0);
      chk({tag, "_instr"}, if_id_instr,           32'h0);
      chk({tag, "_pc"},    if_id_pc,              32'h0);
      chk({tag, "_pc4"},   if_id_pc4,             32'h4);
      chk({tag, "_valid"}, 32'(if_id_valid),      32'h0);
      chk({tag, "_mis"},   32'(fetch_misaligned), 32'h0);
      chk({tag, "_cnt"},   fetch_count,           32'h0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      #1;
      chk_reset_state("rst0");
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;

      // Free-running fetch of words 0..3
      step(0, 0, 0);
      chk("seq1_instr", if_id_instr, 32'h2008_0005);
      chk("seq1_valid", 32'(if_id_valid), 32'h1);
      repeat (3) step(0, 0, 0);
      chk("seq4_addr",  imem_addr,   32'h10);
      chk("seq4_instr", if_id_instr, 32'hAC0A_0000);
      chk("seq4_cnt",   fetch_count, 32'd4);

      // Back to 0x4 so that pc=0x8 holds word1 in IF/ID
      step(0, 1, 32'h4);
      step(0, 0, 0);
      chk("pre_stall_addr",  imem_addr,   32'h8);
      chk("pre_stall_instr", if_id_instr, 32'h2009_0003);

      repeat (3) step(1, 0, 0);
      chk("stall_addr",  imem_addr,   32'h8);
      chk("stall_instr", if_id_instr, 32'h2009_0003);
      chk("stall_cnt",   fetch_count, 32'd5);

      step(0, 0, 0);
      chk("unstall_instr", if_id_instr, 32'h0109_5020);
      chk("unstall_pc",    if_id_pc,    32'h8);
      chk("unstall_addr",  imem_addr,   32'hC);

      // Redirect to 0x40 from pc=0xC
      step(0, 1, 32'h40);
      chk("redir_addr",  imem_addr,   32'h40);
      chk("redir_instr", if_id_instr, 32'h0);
      chk("redir_valid", 32'(if_id_valid), 32'h0);
      chk("redir_cnt",   fetch_count, 32'd6);
      step(0, 0, 0);
      chk("post_redir_instr", if_id_instr, 32'h1000_0010);
      chk("post_redir_pc",    if_id_pc,    32'h40);

      // Redirect beats stall
      step(1, 1, 32'h20);
      chk("rs_addr",  imem_addr, 32'h20);
      chk("rs_valid", 32'(if_id_valid), 32'h0);

      // Misaligned target
      step(0, 1, 32'h46);
      chk("mis_addr",  imem_addr, 32'h44);
      chk("mis_pulse", 32'(fetch_misaligned), 32'h1);
      step(0, 0, 0);
      chk("mis_clear", 32'(fetch_misaligned), 32'h0);

      // Redirect held for 3 cycles
      repeat (3) step(0, 1, 32'h18);
      chk("hold_redir_addr",  imem_addr, 32'h18);
      chk("hold_redir_valid", 32'(if_id_valid), 32'h0);
      step(0, 0, 0);
      chk("hold_redir_instr", if_id_instr, 32'h1000_0006);
      chk("hold_redir_cnt",   fetch_count, 32'd9);

      // Asynchronous reset between edges, with pc=0x1C and the pulse high
      step(0, 1, 32'h1D);
      chk("pre_rst_addr", imem_addr, 32'h1C);
      chk("pre_rst_mis",  32'(fetch_misaligned), 32'h1);
      chk_en = 1'b0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      #2 reset = 1'b1;
      #1;
      chk_reset_state("async");
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      step(0, 0, 0);
      chk("after_rst_instr", if_id_instr, 32'h2008_0005);
      chk("after_rst_cnt",   fetch_count, 32'd1);

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFC);
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 0);
      chk("wrap_addr",  imem_addr,   32'h0);
      chk("wrap_pc",    if_id_pc,    32'hFFFF_FFFC);
      chk("wrap_pc4",   if_id_pc4,   32'h0);
      chk("wrap_instr", if_id_instr, 32'h1000_00FF);
      step(0, 0, 0);
      chk("wrap_next_addr", imem_addr, 32'h4);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
